// File: rtl/param_barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module   : param_barrel_shifter
// Purpose  : WIDTH-bit data register with parallel load, logical left/right,
//            arithmetic right and rotate left/right. Commands arrive over a
//            valid/ready handshake; a shift of N bits advances at most
//            MAX_STEP bits per clock, so long shifts span several cycles
//            while o_busy is high.
// Ports    : clk          rising-edge clock
//            rst          asynchronous reset, active-high
//            i_cmd_valid  command present
//            o_cmd_ready  command can be accepted (state IDLE)
//            i_cmd_op     0=LOAD 1=LSL 2=LSR 3=ASR 4=ROL 5=ROR 6/7=NOP
//            i_cmd_amt    shift amount 0..WIDTH-1 (ignored for LOAD)
//            i_inbit      fill bit for LSL/LSR, captured at accept
//            i_in         parallel load data
//            o_out        data register
//            o_busy       multi-cycle shift in progress (state RUN)
//            o_done       one-cycle pulse when a command completes
// Revision : 1.0 - initial release
// ============================================================================
module param_barrel_shifter #(
  parameter  int WIDTH    = 8,
  parameter  int MAX_STEP = 2,
  localparam int SHW      = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [2:0]       i_cmd_op,
  input  logic [SHW-1:0]   i_cmd_amt,
  input  logic             i_inbit,
  input  logic [WIDTH-1:0] i_in,
  output logic [WIDTH-1:0] o_out,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [2:0] c_OP_LOAD = 3'd0;
  localparam logic [2:0] c_OP_LSL  = 3'd1;
  localparam logic [2:0] c_OP_LSR  = 3'd2;
  localparam logic [2:0] c_OP_ASR  = 3'd3;
  localparam logic [2:0] c_OP_ROL  = 3'd4;
  localparam logic [2:0] c_OP_ROR  = 3'd5;

  localparam logic [SHW-1:0] c_MAX_STEP  = SHW'(MAX_STEP);
  localparam logic [SHW:0]   c_WIDTH_EXT = (SHW+1)'(WIDTH);
  localparam logic [WIDTH-1:0] c_ONES    = {WIDTH{1'b1}};

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_out;
  logic [SHW-1:0]   r_rem;
  logic [2:0]       r_op;
  logic             r_fill;
  logic             r_done;

  logic             w_idle;
  logic             w_is_shift;
  logic [SHW-1:0]   w_src_amt;
  logic [SHW-1:0]   w_step;
  logic [2:0]       w_step_op;
  logic             w_step_fill;
  logic [SHW:0]     w_rot_amt;
  logic [WIDTH-1:0] w_shifted;

  assign w_idle     = (r_state == S_IDLE);
  assign w_is_shift = (i_cmd_op inside {c_OP_LSL, c_OP_LSR, c_OP_ASR, c_OP_ROL, c_OP_ROR});

  // In IDLE the step is taken straight from the incoming command so the
  // accept edge already performs the first step; in RUN the captured
  // copies drive it so later changes on the inputs cannot disturb it.
  assign w_src_amt   = w_idle ? i_cmd_amt : r_rem;
  assign w_step      = (w_src_amt > c_MAX_STEP) ? c_MAX_STEP : w_src_amt;
  assign w_step_op   = w_idle ? i_cmd_op  : r_op;
  assign w_step_fill = w_idle ? i_inbit   : r_fill;

  // Complementary shift for rotates; the step is never 0 when a rotate is
  // actually applied, so this stays within 1..WIDTH-1.
  assign w_rot_amt = c_WIDTH_EXT - {1'b0, w_step};

  always_comb begin
    w_shifted = r_out;
    case (w_step_op)
      c_OP_LSL: w_shifted = (r_out << w_step) | (w_step_fill ? ~(c_ONES << w_step) : '0);
      c_OP_LSR: w_shifted = (r_out >> w_step) | (w_step_fill ? ~(c_ONES >> w_step) : '0);
      c_OP_ASR: w_shifted = WIDTH'($signed(r_out) >>> w_step);
      c_OP_ROL: w_shifted = (r_out << w_step) | (r_out >> w_rot_amt);
      c_OP_ROR: w_shifted = (r_out >> w_step) | (r_out << w_rot_amt);
      default:  w_shifted = r_out;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_out   <= '0;
      r_rem   <= '0;
      r_op    <= '0;
      r_fill  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_cmd_valid) begin
            if (i_cmd_op == c_OP_LOAD) begin
              r_out  <= i_in;
              r_done <= 1'b1;
            end else if (!w_is_shift || (i_cmd_amt == '0)) begin
              // Reserved op or zero-length shift: completes with no change.
              r_done <= 1'b1;
            end else begin
              r_op   <= i_cmd_op;
              r_fill <= i_inbit;
              r_out  <= w_shifted;
              r_rem  <= i_cmd_amt - w_step;
              if (i_cmd_amt == w_step) begin
                r_done <= 1'b1;
              end else begin
                r_state <= S_RUN;
              end
            end
          end
        end
        S_RUN: begin
          r_out <= w_shifted;
          r_rem <= r_rem - w_step;
          if (r_rem == w_step) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_cmd_ready = w_idle;
  assign o_busy      = (r_state == S_RUN);
  assign o_done      = r_done;
  assign o_out       = r_out;

endmodule
`default_nettype wire
